// File: rtl/branch_redirect_if.sv
// Purpose : groups the branch-redirect handshake/bus signals between the
//           branch resolution stage and the fetch-PC block.
// Latency : none (pure wiring). Backpressure: 'stall' holds the fetch PC.
// Ports   : master = branch/decode side (drives stall, br_valid, take_branch,
//           is_jump, target; observes pc, pc_valid, flush, redirect_count).
//           slave  = branch_redirect block (the reverse directions).
// Config  : BRANCH_MISALIGN_TRAP_EN adds the 'trap' signal.
interface branch_redirect_if;
  logic        stall;
  logic        br_valid;
  logic        take_branch;
  logic        is_jump;
  logic [31:0] target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [15:0] redirect_count;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic        trap;
`endif

  modport master (
    output stall,
    output br_valid,
    output take_branch,
    output is_jump,
    output target,
    input  pc,
    input  pc_valid,
    input  flush,
    input  redirect_count
`ifdef BRANCH_MISALIGN_TRAP_EN
    , input trap
`endif
  );

  modport slave (
    input  stall,
    input  br_valid,
    input  take_branch,
    input  is_jump,
    input  target,
    output pc,
    output pc_valid,
    output flush,
    output redirect_count
`ifdef BRANCH_MISALIGN_TRAP_EN
    , output trap
`endif
  );
endinterface

// File: rtl/branch_redirect.sv
// Purpose : fetch-PC sequencer; takes branch/jump redirects and inserts a
//           FLUSH_CYCLES-long bubble (flush=1, pc_valid=0) after each one.
// Latency : all outputs registered; a redirect shows up one cycle after the
//           input cycle. Backpressure: stall holds pc in RUN; a redirect
//           overrides stall; stall and br_valid are ignored while flushing.
// Ports   : clk, rst_n (async active-low); io_br (branch_redirect_if.slave):
//           in  stall, br_valid, take_branch, is_jump, target[31:0]
//           out pc[31:0], pc_valid, flush, redirect_count[15:0] (+ trap)
// Config  : define BRANCH_MISALIGN_TRAP_EN to trap on a taken redirect whose
//           target is not word aligned (sticky TRAP state, adds 'trap').
//           Without it the target's low two bits are dropped.
module branch_redirect #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2            // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_redirect_if.slave io_br
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

`ifdef BRANCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_TRAP} state_t;
`else
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pc_valid;
  logic        r_flush;
  logic [3:0]  r_flush_cnt;
  logic [15:0] r_redirect_cnt;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic        r_trap;
`endif

  logic        w_redirect;
  logic [31:0] w_target_aligned;

  assign w_redirect       = io_br.br_valid & (io_br.take_branch | io_br.is_jump);
  assign w_target_aligned = io_br.target & ~32'd3;

`ifdef BRANCH_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = |io_br.target[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_pc_valid     <= 1'b0;
      r_flush        <= 1'b0;
      r_flush_cnt    <= 4'd0;
      r_redirect_cnt <= 16'd0;
`ifdef BRANCH_MISALIGN_TRAP_EN
      r_trap         <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              // pc and redirect_count deliberately untouched
              r_state    <= ST_TRAP;
              r_trap     <= 1'b1;
              r_flush    <= 1'b1;
              r_pc_valid <= 1'b0;
            end else
`endif
            begin
              r_state     <= ST_FLUSH;
              r_pc        <= w_target_aligned;
              r_flush_cnt <= FLUSH_LOAD;
              r_flush     <= 1'b1;
              r_pc_valid  <= 1'b0;
              if (r_redirect_cnt != 16'hFFFF) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
              end
            end
          end else if (!r_pc_valid) begin
            // First edge after reset release: RESET_PC becomes valid but
            // is not yet advanced, so it gets one full fetch cycle.
            r_pc_valid <= 1'b1;
          end else if (!io_br.stall) begin
            r_pc <= r_pc + 32'd4;
          end
        end

        ST_FLUSH: begin
          r_flush_cnt <= r_flush_cnt - 4'd1;
          // Leaving on count==1 gives exactly FLUSH_CYCLES bubble cycles;
          // pc stays at the target for its first valid cycle.
          if (r_flush_cnt == 4'd1) begin
            r_state    <= ST_RUN;
            r_flush    <= 1'b0;
            r_pc_valid <= 1'b1;
          end
        end

`ifdef BRANCH_MISALIGN_TRAP_EN
        ST_TRAP: begin
          // Sticky until reset.
          r_state <= ST_TRAP;
        end
`endif

        default: begin
          r_state    <= ST_RUN;
          r_flush    <= 1'b0;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_br.pc             = r_pc;
  assign io_br.pc_valid       = r_pc_valid;
  assign io_br.flush          = r_flush;
  assign io_br.redirect_count = r_redirect_cnt;
`ifdef BRANCH_MISALIGN_TRAP_EN
  assign io_br.trap           = r_trap;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Purpose : self-checking bench for branch_redirect; directed scenarios then
//           randomized traffic against a behavioural model of the fetch PC.
// Latency : model outputs are compared every cycle on the falling edge.
module tb_branch_redirect;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FC     = 2;

  logic clk;
  logic rst_n;

  branch_redirect_if bif ();

  branch_redirect #(
    .RESET_PC    (RST_PC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io_br(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: remaining bubble cycles, whether the PC has become
  // valid since reset, and a sticky trap flag.
  logic [31:0] m_pc;
  bit          m_started;
  int          m_flush_left;
  int          m_count;
  bit          m_trap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc         = RST_PC;
    m_started    = 1'b0;
    m_flush_left = 0;
    m_count      = 0;
    m_trap       = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit bv, input bit tk, input bit jp,
                            input logic [31:0] tg);
    if (m_trap) return;
    if (m_flush_left > 0) begin
      m_flush_left--;
      return;
    end
    if (bv && (tk || jp)) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
      if (tg[1:0] != 2'b00) begin
        m_trap = 1'b1;
        return;
      end
`endif
      m_pc         = tg - (tg % 4);
      m_flush_left = FC;
      m_started    = 1'b1;
      if (m_count < 65535) m_count++;
      return;
    end
    if (!m_started) m_started = 1'b1;
    else if (!st)   m_pc = m_pc + 32'd4;
  endtask

  task automatic check_model(input string where);
    bit exp_flush;
    bit exp_valid;
    exp_flush = (m_flush_left > 0) || m_trap;
    exp_valid = m_started && (m_flush_left == 0) && !m_trap;
    chk({where, ".pc"},       bif.pc,                   m_pc);
    chk({where, ".pc_valid"}, {31'd0, bif.pc_valid},    {31'd0, exp_valid});
    chk({where, ".flush"},    {31'd0, bif.flush},       {31'd0, exp_flush});
    chk({where, ".count"},    {16'd0, bif.redirect_count}, 32'(m_count));
`ifdef BRANCH_MISALIGN_TRAP_EN
    chk({where, ".trap"},     {31'd0, bif.trap},        {31'd0, m_trap});
`endif
  endtask

  // One clock: drive inputs (called just after a falling edge), advance
  // the model at the rising edge, compare on the next falling edge.
  task automatic cyc(input bit st, input bit bv, input bit tk, input bit jp,
                     input logic [31:0] tg, input string where);
    bif.stall       = st;
    bif.br_valid    = bv;
    bif.take_branch = tk;
    bif.is_jump     = jp;
    bif.target      = tg;
    @(posedge clk);
    model_step(st, bv, tk, jp, tg);
    @(negedge clk);
    check_model(where);
  endtask

  task automatic idle(input string where);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, where);
  endtask

  // Asynchronous reset pulse: checked 1ns after assertion, released on a
  // falling edge so the next rising edge is the first after deassertion.
  task automatic pulse_reset(input string where);
    #2;
    rst_n           = 1'b0;
    bif.br_valid    = 1'b0;
    bif.take_branch = 1'b0;
    bif.is_jump     = 1'b0;
    bif.stall       = 1'b0;
    #1;
    model_reset();
    check_model(where);
    chk({where, ".rst_pc"},    bif.pc, RST_PC);
    chk({where, ".rst_flush"}, {31'd0, bif.flush}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bif.stall       = 1'b0;
    bif.br_valid    = 1'b0;
    bif.take_branch = 1'b0;
    bif.is_jump     = 1'b0;
    bif.target      = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    chk("reset.pc_valid_const", {31'd0, bif.pc_valid}, 32'd0);
    chk("reset.count_const",    {16'd0, bif.redirect_count}, 32'd0);
    rst_n = 1'b1;

    // Reset release, free-running fetch: 0, 4, 8
    idle("boot0"); chk("boot0.pc_const", bif.pc, 32'h0);
    chk("boot0.valid_const", {31'd0, bif.pc_valid}, 32'd1);
    idle("boot1"); chk("boot1.pc_const", bif.pc, 32'h4);
    idle("boot2"); chk("boot2.pc_const", bif.pc, 32'h8);

    // Taken branch to 0x100: two bubble cycles, then 0x100 valid, then 0x104
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, "br0");
    chk("br0.pc_const",    bif.pc, 32'h100);
    chk("br0.flush_const", {31'd0, bif.flush}, 32'd1);
    idle("br1");
    chk("br1.flush_const", {31'd0, bif.flush}, 32'd1);
    idle("br2");
    chk("br2.valid_const", {31'd0, bif.pc_valid}, 32'd1);
    chk("br2.pc_const",    bif.pc, 32'h100);
    idle("br3");
    chk("br3.pc_const",    bif.pc, 32'h104);
    chk("br3.count_const", {16'd0, bif.redirect_count}, 32'd1);

    // Not-taken with stall: hold, no flush
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, "nt");
    chk("nt.pc_const", bif.pc, 32'h104);

    // Jump wins over stall; br_valid pulse during FLUSH ignored
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, "jmp0");
    chk("jmp0.pc_const", bif.pc, 32'h40);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, "jmp1");
    idle("jmp2");
    chk("jmp2.pc_const",    bif.pc, 32'h40);
    chk("jmp2.count_const", {16'd0, bif.redirect_count}, 32'd2);

    // PC wrap at the top of the address space
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, "wrap0");
    idle("wrap1"); idle("wrap2");
    chk("wrap2.pc_const", bif.pc, 32'hFFFF_FFFC);
    idle("wrap3");
    chk("wrap3.pc_const", bif.pc, 32'h0);

    // Reset in the middle of a flush
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, "mid0");
    pulse_reset("midrst");
    idle("mid1"); idle("mid2");

    // Misaligned target
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h102, "mis0");
`ifdef BRANCH_MISALIGN_TRAP_EN
    chk("mis0.trap_const", {31'd0, bif.trap}, 32'd1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h400, "mis_hold");
    chk("mis_hold.pc_const", bif.pc, 32'h4);
`else
    chk("mis0.pc_const", bif.pc, 32'h100);
`endif
    pulse_reset("misrst");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      bit st, bv, tk, jp;
      tg = $urandom;
      if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
      st = ($urandom_range(0, 9) < 3);
      bv = ($urandom_range(0, 9) < 3);
      tk = $urandom_range(0, 1) == 1;
      jp = ($urandom_range(0, 3) == 0);
      cyc(st, bv, tk, jp, tg, "rnd");
      if ($urandom_range(0, 99) == 0) pulse_reset("rndrst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
